spi_shift_unit: RTL and testbench
=================================

Name: spi_shift_unit

Overview:
- Parametrised SPI-slave shift/rotate coprocessor; next generation of the team's fixed 32-bit SPI shifter.
- Adds:
  - generic operand width
  - rotate operations
  - defined over-range shift amounts
  - a status byte ahead of the result
  - synchronised SPI inputs
  - abort reporting
- Sits on the system SPI bus beside the other SPI arithmetic slaves, mode 0 (CPOL=0, CPHA=0), MSB first.

Parameters:
- DATA_WIDTH, 32: operand/result width; power of two, 8..64.
- SYNC_STAGES, 2: synchroniser depth on spi_sclk/spi_nss/spi_mosi, >=2.

Ports:
- clock  input  1  system clock; must be >= 4x SPI sclk frequency.
- reset  input  1  reset; asynchronous, active-high.
- spi_sclk  input  1  SPI clock from master.
- spi_nss  input  1  chip select, active-low.
- spi_mosi  input  1  master-out data.
- spi_miso  output  1  slave-out data.
- busy  output  1  high while a frame is in progress (state != IDLE).
- done  output  1  one-clock pulse when the last result bit has been shifted out.
- aborted  output  1  one-clock pulse when nss rises before frame completion.
- last_status  output  8  status byte of the most recent executed op.

Behaviour:
- Reset values: spi_miso=0, busy=0, done=0, aborted=0, last_status=0, state=IDLE, all registers 0.
- Inputs pass through SYNC_STAGES flops. rise/fall = single-cycle pulses from the synchronised sclk, qualified by synchronised nss=0. Synchroniser latency is SYNC_STAGES+1 clocks.
- Frame layout:
  - RX: 8-bit command (opcode = cmd[3:0], cmd[7:4] ignored), then DATA_WIDTH bits A, then DATA_WIDTH bits B.
  - TX: 8-bit status, then DATA_WIDTH bits result.
- Opcodes: 0110 SHL, 0111 SHR, 1000 SAR, 1001 ROL, 1010 ROR. Any other value is illegal.
- Shift amount: SH_W = $clog2(DATA_WIDTH); amt = B[SH_W-1:0]; over = |B[DATA_WIDTH-1:SH_W].
  - SHL/SHR with over=1 -> result 0.
  - SAR with over=1 -> result = all copies of A[MSB].
  - ROL/ROR use amt only (modulo DATA_WIDTH); over is still reported.
  - Illegal opcode -> result = A, err=1.
- Status byte = {err, over, 2'b00, opcode}.
- State machine (bit_cnt sized for DATA_WIDTH+8):
  - IDLE: nss=0 -> RX_CMD, bit_cnt=0.
  - RX_CMD/RX_A/RX_B: each rise shifts mosi into rx_sr LSB and increments bit_cnt. On the 8th / DATA_WIDTH-th rise, latch the field, clear bit_cnt, advance. RX_B completion -> EXEC.
  - EXEC (1 clock): compute result; load tx_sr = {status, result}; last_status <= status -> TX.
  - TX: spi_miso = tx_sr MSB. tx_armed is set by the first rise in TX. Each fall while tx_armed shifts tx_sr left, filling with 0. This means the fall ending the last RX bit is ignored. After 8+DATA_WIDTH shifting falls, pulse done -> WAIT_NSS.
  - WAIT_NSS: spi_miso=0; nss=1 -> IDLE. Extra sclk edges are ignored.
- spi_miso = 0 in every state except TX.
- nss=1 in RX_CMD/RX_A/RX_B/EXEC/TX -> IDLE next clock, aborted pulse. Latched fields and last_status are not updated unless EXEC was already reached.
- rise and fall cannot coincide (>=4x oversampling). Behaviour at lower clock ratios is undefined.
- Reset mid-frame: immediate return to reset values. The master must drop nss before starting a new frame.

Decomposition:
- Package spi_shift_pkg:
  - opcode localparams OP_SHL..OP_ROR
  - STATUS_W=8, CMD_W=8
  - state_t enum {IDLE, RX_CMD, RX_A, RX_B, EXEC, TX, WAIT_NSS}
  - status bit-index constants
- Sub-module spi_edge_sync (parameter SYNC_STAGES): synchronises sclk/nss/mosi; outputs nss_s, mosi_s, rise, fall.
- Shift/rotate datapath is an always_comb function inside spi_shift_unit.

Test Plan (DATA_WIDTH=32, sclk = clock/8):
- SHL: A=0x0000_00F1, B=4 -> status 0x06, result 0x0000_0F10, one done pulse, last_status=0x06.
- SAR: A=0x8000_0010, B=4 -> status 0x08, result 0xF800_0001. Same A with B=40 (over) -> status 0x48, result 0xFFFF_FFFF.
- ROR: A=0x1234_5678, B=36 -> status 0x4A, result 0x8123_4567. ROL with B=8 -> status 0x09, result 0x3456_7812.
- Illegal opcode 0x0F: A=0xDEAD_BEEF, B=1 -> status 0x8F, result 0xDEAD_BEEF.
- Abort: raise nss after 20 bits of A -> aborted pulse, busy=0, last_status unchanged. A following full SHR frame (A=0x100, B=8) -> result 0x0000_0001.
- Reset asserted during TX -> spi_miso=0, busy=0, state IDLE. Back-to-back frames with 2 idle sclk periods between them both complete.

Source files
------------

// File: rtl/spi_shift_pkg.sv
// Shared types and constants for the SPI shift/rotate coprocessor.
package spi_shift_pkg;

  localparam int STATUS_W = 8;
  localparam int CMD_W    = 8;
  localparam int OP_W     = 4;

  localparam logic [OP_W-1:0] OP_SHL = 4'h6;
  localparam logic [OP_W-1:0] OP_SHR = 4'h7;
  localparam logic [OP_W-1:0] OP_SAR = 4'h8;
  localparam logic [OP_W-1:0] OP_ROL = 4'h9;
  localparam logic [OP_W-1:0] OP_ROR = 4'hA;

  // Status byte layout: {err, over, 2'b00, opcode}
  localparam int ST_ERR  = 7;
  localparam int ST_OVER = 6;

  typedef enum logic [2:0] {
    IDLE,
    RX_CMD,
    RX_A,
    RX_B,
    EXEC,
    TX,
    WAIT_NSS
  } state_t;

endpackage

// File: rtl/spi_shift_unit_if.sv
// SPI pins plus frame status outputs of the shift/rotate coprocessor.
interface spi_shift_unit_if
  import spi_shift_pkg::*;
;
  logic                spi_sclk;
  logic                spi_nss;
  logic                spi_mosi;
  logic                spi_miso;
  logic                busy;
  logic                done;
  logic                aborted;
  logic [STATUS_W-1:0] last_status;

  modport master (
    output spi_sclk, spi_nss, spi_mosi,
    input  spi_miso, busy, done, aborted, last_status
  );

  modport slave (
    input  spi_sclk, spi_nss, spi_mosi,
    output spi_miso, busy, done, aborted, last_status
  );

endinterface

// File: rtl/spi_edge_sync.sv
// Synchronises the SPI pins into the clock domain and detects sclk edges.
// rise/fall are one-clock pulses, only while the synchronised nss is low.
module spi_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic sclk,
  input  logic nss,
  input  logic mosi,
  output logic nss_s,
  output logic mosi_s,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sclk_q;
  logic [SYNC_STAGES-1:0] nss_q;
  logic [SYNC_STAGES-1:0] mosi_q;
  logic                   sclk_d;
  logic                   sclk_s;

  // nss chain resets to the deselected level so leaving reset never looks like a frame start.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sclk_q <= '0;
      nss_q  <= '1;
      mosi_q <= '0;
      sclk_d <= 1'b0;
    end else begin
      sclk_q <= {sclk_q[SYNC_STAGES-2:0], sclk};
      nss_q  <= {nss_q[SYNC_STAGES-2:0], nss};
      mosi_q <= {mosi_q[SYNC_STAGES-2:0], mosi};
      sclk_d <= sclk_s;
    end
  end

  assign sclk_s = sclk_q[SYNC_STAGES-1];
  assign nss_s  = nss_q[SYNC_STAGES-1];
  assign mosi_s = mosi_q[SYNC_STAGES-1];
  assign rise   = sclk_s & ~sclk_d & ~nss_s;
  assign fall   = ~sclk_s & sclk_d & ~nss_s;

endmodule

// File: rtl/spi_shift_unit.sv
// SPI-slave (mode 0, MSB first) shift/rotate coprocessor: cmd, A, B in; status, result out.
// Pins are synchronised (SYNC_STAGES+1 clocks); nss high mid-frame aborts back to IDLE.
module spi_shift_unit
  import spi_shift_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clock,
  input  logic             reset,
  spi_shift_unit_if.slave  bus
);

  localparam int SH_W  = $clog2(DATA_WIDTH);
  localparam int TX_W  = STATUS_W + DATA_WIDTH;
  localparam int CNT_W = $clog2(TX_W) + 1;

  localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(CMD_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] TX_LAST   = CNT_W'(TX_W - 1);

  logic nss_s, mosi_s, rise, fall;

  spi_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clock  (clock),
    .reset  (reset),
    .sclk   (bus.spi_sclk),
    .nss    (bus.spi_nss),
    .mosi   (bus.spi_mosi),
    .nss_s  (nss_s),
    .mosi_s (mosi_s),
    .rise   (rise),
    .fall   (fall)
  );

  state_t                state_q, state_n;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_n;
  logic [DATA_WIDTH-2:0] rx_sr_q, rx_sr_n;
  logic [OP_W-1:0]       op_q, op_n;
  logic [DATA_WIDTH-1:0] a_q, a_n;
  logic [DATA_WIDTH-1:0] b_q, b_n;
  logic [TX_W-1:0]       tx_sr_q, tx_sr_n;
  logic                  tx_armed_q, tx_armed_n;
  logic                  done_q, done_n;
  logic                  aborted_q, aborted_n;
  logic [STATUS_W-1:0]   last_status_q, last_status_n;

  logic [DATA_WIDTH-1:0] rx_shift;
  assign rx_shift = {rx_sr_q, mosi_s};

  // Shift/rotate datapath, evaluated from the latched operands.
  logic [SH_W-1:0]       amt;
  logic [SH_W:0]         inv_amt;
  logic                  over;
  logic                  err;
  logic [DATA_WIDTH-1:0] result;
  logic [STATUS_W-1:0]   status;

  always_comb begin
    amt     = b_q[SH_W-1:0];
    over    = |b_q[DATA_WIDTH-1:SH_W];
    inv_amt = (SH_W+1)'(DATA_WIDTH) - {1'b0, amt};
    err     = 1'b0;
    result  = '0;
    case (op_q)
      OP_SHL:  result = over ? '0 : (a_q << amt);
      OP_SHR:  result = over ? '0 : (a_q >> amt);
      OP_SAR:  result = over ? {DATA_WIDTH{a_q[DATA_WIDTH-1]}}
                             : $unsigned($signed(a_q) >>> amt);
      // inv_amt equals DATA_WIDTH when amt is 0, which shifts the wrap term out entirely.
      OP_ROL:  result = (a_q << amt) | (a_q >> inv_amt);
      OP_ROR:  result = (a_q >> amt) | (a_q << inv_amt);
      default: begin
        result = a_q;
        err    = 1'b1;
      end
    endcase
    status             = '0;
    status[ST_ERR]     = err;
    status[ST_OVER]    = over;
    status[OP_W-1:0]   = op_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      bit_cnt_q     <= '0;
      rx_sr_q       <= '0;
      op_q          <= '0;
      a_q           <= '0;
      b_q           <= '0;
      tx_sr_q       <= '0;
      tx_armed_q    <= 1'b0;
      done_q        <= 1'b0;
      aborted_q     <= 1'b0;
      last_status_q <= '0;
    end else begin
      state_q       <= state_n;
      bit_cnt_q     <= bit_cnt_n;
      rx_sr_q       <= rx_sr_n;
      op_q          <= op_n;
      a_q           <= a_n;
      b_q           <= b_n;
      tx_sr_q       <= tx_sr_n;
      tx_armed_q    <= tx_armed_n;
      done_q        <= done_n;
      aborted_q     <= aborted_n;
      last_status_q <= last_status_n;
    end
  end

  always_comb begin
    state_n       = state_q;
    bit_cnt_n     = bit_cnt_q;
    rx_sr_n       = rx_sr_q;
    op_n          = op_q;
    a_n           = a_q;
    b_n           = b_q;
    tx_sr_n       = tx_sr_q;
    tx_armed_n    = tx_armed_q;
    done_n        = 1'b0;
    aborted_n     = 1'b0;
    last_status_n = last_status_q;

    if (state_q != IDLE && state_q != WAIT_NSS && nss_s) begin
      state_n    = IDLE;
      bit_cnt_n  = '0;
      tx_armed_n = 1'b0;
      aborted_n  = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          tx_armed_n = 1'b0;
          if (!nss_s) begin
            state_n   = RX_CMD;
            bit_cnt_n = '0;
          end
        end
        RX_CMD: if (rise) begin
          rx_sr_n = rx_shift[DATA_WIDTH-2:0];
          if (bit_cnt_q == CMD_LAST) begin
            op_n      = rx_shift[OP_W-1:0];
            bit_cnt_n = '0;
            state_n   = RX_A;
          end else begin
            bit_cnt_n = bit_cnt_q + 1'b1;
          end
        end
        RX_A: if (rise) begin
          rx_sr_n = rx_shift[DATA_WIDTH-2:0];
          if (bit_cnt_q == DATA_LAST) begin
            a_n       = rx_shift;
            bit_cnt_n = '0;
            state_n   = RX_B;
          end else begin
            bit_cnt_n = bit_cnt_q + 1'b1;
          end
        end
        RX_B: if (rise) begin
          rx_sr_n = rx_shift[DATA_WIDTH-2:0];
          if (bit_cnt_q == DATA_LAST) begin
            b_n       = rx_shift;
            bit_cnt_n = '0;
            state_n   = EXEC;
          end else begin
            bit_cnt_n = bit_cnt_q + 1'b1;
          end
        end
        EXEC: begin
          tx_sr_n       = {status, result};
          last_status_n = status;
          tx_armed_n    = 1'b0;
          bit_cnt_n     = '0;
          state_n       = TX;
        end
        TX: begin
          // The fall closing the last RX bit arrives before any TX rise and must not shift.
          if (rise) tx_armed_n = 1'b1;
          if (fall && tx_armed_q) begin
            tx_sr_n = {tx_sr_q[TX_W-2:0], 1'b0};
            if (bit_cnt_q == TX_LAST) begin
              done_n    = 1'b1;
              bit_cnt_n = '0;
              state_n   = WAIT_NSS;
            end else begin
              bit_cnt_n = bit_cnt_q + 1'b1;
            end
          end
        end
        WAIT_NSS: if (nss_s) state_n = IDLE;
        default:  state_n = IDLE;
      endcase
    end
  end

  assign bus.spi_miso    = (state_q == TX) & tx_sr_q[TX_W-1];
  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = done_q;
  assign bus.aborted     = aborted_q;
  assign bus.last_status = last_status_q;

endmodule

// File: tb/tb_spi_shift_unit.sv
// Directed bench for spi_shift_unit at DATA_WIDTH=32 with sclk = clock/8.
module tb_spi_shift_unit;
  import spi_shift_pkg::*;

  localparam int DW      = 32;
  localparam int HALF    = 4;
  localparam int RX_BITS = 8 + 2 * DW;
  localparam int TX_BITS = 8 + DW;
  localparam int NVEC    = 13;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  spi_shift_unit_if bus ();

  spi_shift_unit #(
    .DATA_WIDTH  (DW),
    .SYNC_STAGES (2)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  int checks    = 0;
  int errors    = 0;
  int done_cnt  = 0;
  int abort_cnt = 0;

  always @(negedge clock) begin
    if (bus.done === 1'b1)    done_cnt++;
    if (bus.aborted === 1'b1) abort_cnt++;
  end

  typedef struct packed {
    logic [7:0]    cmd;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [7:0]    st;
    logic [DW-1:0] res;
  } vec_t;

  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic sclk_cycle(input logic mo, output logic mi);
    bus.spi_mosi = mo;
    repeat (HALF) @(negedge clock);
    mi = bus.spi_miso;
    bus.spi_sclk = 1'b1;
    repeat (HALF) @(negedge clock);
    bus.spi_sclk = 1'b0;
  endtask

  task automatic shift_frame(input vec_t v, input int ncyc,
                             output logic [TX_BITS-1:0] rx, output logic rx_miso);
    logic [RX_BITS-1:0] fr;
    logic m;
    fr = {v.cmd, v.a, v.b};
    rx = '0;
    rx_miso = 1'b0;
    bus.spi_nss = 1'b0;
    repeat (HALF) @(negedge clock);
    for (int i = 0; i < ncyc; i++) begin
      sclk_cycle((i < RX_BITS) ? fr[RX_BITS-1-i] : 1'b0, m);
      if (i >= RX_BITS) rx = {rx[TX_BITS-2:0], m};
      else              rx_miso |= m;
    end
  endtask

  task automatic end_frame();
    bus.spi_nss  = 1'b1;
    bus.spi_mosi = 1'b0;
    repeat (4 * HALF) @(negedge clock);
  endtask

  task automatic full_frame(input vec_t v, input string tag);
    logic [TX_BITS-1:0] rx;
    logic rx_miso;
    int d0;
    d0 = done_cnt;
    shift_frame(v, RX_BITS + TX_BITS, rx, rx_miso);
    repeat (6) @(negedge clock);
    check({tag, " status"},      rx[TX_BITS-1:DW], v.st);
    check({tag, " result"},      rx[DW-1:0], v.res);
    check({tag, " done pulses"}, done_cnt - d0, 1);
    check({tag, " last_status"}, bus.last_status, v.st);
    check({tag, " miso in rx"},  rx_miso, 1'b0);
    check({tag, " busy wait"},   bus.busy, 1'b1);
    check({tag, " miso wait"},   bus.spi_miso, 1'b0);
    end_frame();
    check({tag, " busy idle"},   bus.busy, 1'b0);
  endtask

  initial begin
    logic [TX_BITS-1:0] rx;
    logic rx_miso;
    int a0, d0;
    vec_t v;

    vecs[0]  = '{8'h06, 32'h0000_00F1, 32'd4,      8'h06, 32'h0000_0F10};
    vecs[1]  = '{8'h08, 32'h8000_0010, 32'd4,      8'h08, 32'hF800_0001};
    vecs[2]  = '{8'h08, 32'h8000_0010, 32'd40,     8'h48, 32'hFFFF_FFFF};
    vecs[3]  = '{8'h0A, 32'h1234_5678, 32'd36,     8'h4A, 32'h8123_4567};
    vecs[4]  = '{8'h09, 32'h1234_5678, 32'd8,      8'h09, 32'h3456_7812};
    vecs[5]  = '{8'h0F, 32'hDEAD_BEEF, 32'd1,      8'h8F, 32'hDEAD_BEEF};
    vecs[6]  = '{8'h07, 32'h0000_0100, 32'd8,      8'h07, 32'h0000_0001};
    vecs[7]  = '{8'hF6, 32'h0000_0001, 32'd31,     8'h06, 32'h8000_0000};
    vecs[8]  = '{8'h06, 32'hFFFF_FFFF, 32'd32,     8'h46, 32'h0000_0000};
    vecs[9]  = '{8'h09, 32'h0000_A5A5, 32'd0,      8'h09, 32'h0000_A5A5};
    vecs[10] = '{8'h07, 32'h8000_0000, 32'd31,     8'h07, 32'h0000_0001};
    vecs[11] = '{8'h08, 32'h7FFF_FFFF, 32'h100,    8'h48, 32'h0000_0000};
    vecs[12] = '{8'h0A, 32'h1357_9BDF, 32'd32,     8'h4A, 32'h1357_9BDF};

    reset        = 1'b1;
    bus.spi_sclk = 1'b0;
    bus.spi_nss  = 1'b1;
    bus.spi_mosi = 1'b0;
    repeat (3) @(negedge clock);
    check("reset miso",        bus.spi_miso, 1'b0);
    check("reset busy",        bus.busy, 1'b0);
    check("reset done",        bus.done, 1'b0);
    check("reset aborted",     bus.aborted, 1'b0);
    check("reset last_status", bus.last_status, 8'h00);
    reset = 1'b0;
    repeat (8) @(negedge clock);
    check("post-reset busy",   bus.busy, 1'b0);
    check("post-reset pulses", done_cnt + abort_cnt, 0);

    for (int i = 0; i < NVEC; i++) full_frame(vecs[i], $sformatf("vec%0d", i));

    // Abort after 20 bits of A: no result, status of the previous frame kept.
    a0 = abort_cnt;
    d0 = done_cnt;
    v  = '{8'h07, 32'h0000_0100, 32'd8, 8'h07, 32'h0000_0001};
    shift_frame(v, 8 + 20, rx, rx_miso);
    check("abort busy before", bus.busy, 1'b1);
    bus.spi_nss = 1'b1;
    repeat (8) @(negedge clock);
    check("abort pulse",       abort_cnt - a0, 1);
    check("abort busy",        bus.busy, 1'b0);
    check("abort last_status", bus.last_status, vecs[NVEC-1].st);
    check("abort no done",     done_cnt - d0, 0);
    end_frame();
    full_frame(v, "after abort");

    // Reset in the middle of the TX phase.
    shift_frame(vecs[0], RX_BITS + 10, rx, rx_miso);
    check("tx busy before reset", bus.busy, 1'b1);
    reset = 1'b1;
    @(negedge clock);
    check("tx reset miso",        bus.spi_miso, 1'b0);
    check("tx reset busy",        bus.busy, 1'b0);
    check("tx reset last_status", bus.last_status, 8'h00);
    bus.spi_nss = 1'b1;
    repeat (2) @(negedge clock);
    a0 = abort_cnt;
    reset = 1'b0;
    repeat (16) @(negedge clock);
    check("post tx reset busy",  bus.busy, 1'b0);
    check("post tx reset abort", abort_cnt - a0, 0);

    // Back-to-back frames separated by two idle sclk periods.
    full_frame(vecs[4], "b2b first");
    full_frame(vecs[1], "b2b second");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
